// File: rtl/mips_mc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes,
// ULA/ALUSrcB/PCSource/BranchOp codes and the packed control-word layout.
package mips_mc_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [2:0] ULA_ADD   = 3'b000;
  localparam logic [2:0] ULA_SUB   = 3'b001;
  localparam logic [2:0] ULA_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_SEXT     = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ULA    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] ula_operation;
    logic [1:0] pc_source;
    logic [1:0] branch_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_mc_control_next_state.sv
// Combinational next-state map of the multi-cycle control FSM.
// Opcode is consulted only in DECODE and MEMADR, where the IR is stable.
module mc_next_state
  import mips_mc_control_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [3:0] next_state
);

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     next_state = S_EXEC;
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_RWB;
      S_ADDIEX: next_state = S_ADDIWB;
      // MEMWB, RWB, BRANCH, ADDIWB, JUMP and unused codes all return to FETCH
      default:  next_state = S_FETCH;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Moore control FSM for the multi-cycle MIPS datapath: state register, output
// decode, and retired-instruction counter. All outputs read 0 while reset is high.
module mips_mc_control
  import mips_mc_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ula_operation,
  output logic [1:0]       PCSource,
  output logic [1:0]       BranchOp,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q;
  logic [3:0]       next_state;
  ctrl_t            ctrl;
  ctrl_t            ctrl_out;
  logic [CNT_W-1:0] retired_q;

  mc_next_state u_next_state (
    .state      (state_q),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .next_state (next_state)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_t'(next_state);
    end
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_SEXT_SH2;
        ctrl.illegal_op = !is_legal_op(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
      end
      S_MEMRD: begin
        ctrl.ior_d    = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.ior_d      = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.ula_operation = ULA_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        // BranchOp only selects the comparison sense; PCWriteCond stays state-only
        ctrl.alu_src_a     = 1'b1;
        ctrl.ula_operation = ULA_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_op     = (opcode == OP_BEQ) ? BR_EQ :
                             (opcode == OP_BNE) ? BR_NE : BR_NONE;
        ctrl.instr_done    = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      retired_q <= '0;
    end else if (ctrl.instr_done) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign ctrl_out = reset ? '0 : ctrl;

  assign PCWrite       = ctrl_out.pc_write;
  assign PCWriteCond   = ctrl_out.pc_write_cond;
  assign IorD          = ctrl_out.ior_d;
  assign MemRead       = ctrl_out.mem_read;
  assign MemWrite      = ctrl_out.mem_write;
  assign IRWrite       = ctrl_out.ir_write;
  assign MemtoReg      = ctrl_out.mem_to_reg;
  assign RegDst        = ctrl_out.reg_dst;
  assign RegWrite      = ctrl_out.reg_write;
  assign ALUSrcA       = ctrl_out.alu_src_a;
  assign ALUSrcB       = ctrl_out.alu_src_b;
  assign ula_operation = ctrl_out.ula_operation;
  assign PCSource      = ctrl_out.pc_source;
  assign BranchOp      = ctrl_out.branch_op;
  assign instr_done    = ctrl_out.instr_done;
  assign illegal_op    = ctrl_out.illegal_op;
  assign state         = reset ? 4'd0 : state_q;
  assign retired       = reset ? '0 : retired_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: latency table, reset/wrap sequences, and a random
// instruction stream checked against a per-instruction state-path model.
module tb_mips_mc_control;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource, BranchOp;
  logic [2:0]  ula_operation;
  logic [3:0]  state;
  logic        instr_done, illegal_op;
  logic [31:0] retired;

  logic        s_pcw, s_pcwc, s_iord, s_mrd, s_mwr, s_irw, s_m2r, s_rdst, s_rw, s_srca;
  logic [1:0]  s_srcb, s_pcsrc, s_bop;
  logic [2:0]  s_ula;
  logic [3:0]  s_state;
  logic        s_done, s_ill;
  logic [1:0]  s_retired;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mips_mc_control dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ula_operation(ula_operation), .PCSource(PCSource), .BranchOp(BranchOp),
    .state(state), .instr_done(instr_done), .illegal_op(illegal_op), .retired(retired)
  );

  // Narrow counter copy so the modulo wrap is reachable in a few instructions
  mips_mc_control #(.CNT_W(2)) dut_small (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(s_pcw), .PCWriteCond(s_pcwc), .IorD(s_iord), .MemRead(s_mrd),
    .MemWrite(s_mwr), .IRWrite(s_irw), .MemtoReg(s_m2r), .RegDst(s_rdst),
    .RegWrite(s_rw), .ALUSrcA(s_srca), .ALUSrcB(s_srcb),
    .ula_operation(s_ula), .PCSource(s_pcsrc), .BranchOp(s_bop),
    .state(s_state), .instr_done(s_done), .illegal_op(s_ill), .retired(s_retired)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] dut_vec();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
            RegWrite, ALUSrcA, ALUSrcB, ula_operation, PCSource, BranchOp,
            instr_done, illegal_op};
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02};
  endfunction

  // Sequence of states an instruction walks through (stalls not included), -1 ends it
  function automatic int path_state(input logic [5:0] op, input int i);
    int p[6];
    case (op)
      6'h23:        p = '{0, 1, 2, 3, 4, -1};
      6'h2B:        p = '{0, 1, 2, 5, -1, -1};
      6'h00:        p = '{0, 1, 6, 7, -1, -1};
      6'h08:        p = '{0, 1, 9, 10, -1, -1};
      6'h04, 6'h05: p = '{0, 1, 8, -1, -1, -1};
      6'h02:        p = '{0, 1, 11, -1, -1, -1};
      default:      p = '{0, 1, -1, -1, -1, -1};
    endcase
    return p[i];
  endfunction

  // Expected strobes for a state, in the same order as dut_vec()
  function automatic logic [20:0] exp_out(input int st, input bit mr, input logic [5:0] op);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, done, ill;
    logic [1:0] srcb, pcsrc, bop;
    logic [2:0] ula;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, done, ill} = '0;
    srcb = 2'd0; pcsrc = 2'd0; bop = 2'd0; ula = 3'd0;
    case (st)
      0:  begin mrd = 1; srcb = 2'd1; irw = mr; pcw = mr; end
      1:  begin srcb = 2'd3; ill = !legal(op); end
      2:  begin srca = 1; srcb = 2'd2; end
      3:  begin iord = 1; mrd = 1; end
      4:  begin m2r = 1; rw = 1; done = 1; end
      5:  begin iord = 1; mwr = 1; done = mr; end
      6:  begin srca = 1; ula = 3'd2; end
      7:  begin rdst = 1; rw = 1; done = 1; end
      8:  begin srca = 1; ula = 3'd1; pcwc = 1; pcsrc = 2'd1; done = 1;
                bop = (op == 6'h04) ? 2'd1 : 2'd2; end
      9:  begin srca = 1; srcb = 2'd2; end
      10: begin rw = 1; done = 1; end
      11: begin pcw = 1; pcsrc = 2'd2; done = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, ula, pcsrc, bop, done, ill};
  endfunction

  // Runs one instruction from FETCH; holds mem_ready low for stall_n cycles in stall_st
  task automatic run_instr(input logic [5:0] op, input int stall_st, input int stall_n,
                           output int cycles, output int mw, output int done, output int ill);
    int stalled = 0;
    bit fin;
    cycles = 0; mw = 0; done = 0; ill = 0;
    opcode = op;
    for (int k = 0; k < 30; k++) begin
      if (int'(state) == stall_st && stalled < stall_n) begin
        mem_ready = 1'b0;
        stalled++;
      end else begin
        mem_ready = 1'b1;
      end
      @(negedge clock);
      cycles++;
      mw += int'(MemWrite);
      done += int'(instr_done);
      ill += int'(illegal_op);
      fin = instr_done || illegal_op;
      @(posedge clock); #1;
      if (fin) break;
    end
  endtask

  typedef struct {
    logic [5:0] op;
    int stall_st;
    int stall_n;
    int exp_cycles;
    int exp_mw;
    int exp_done;
    int exp_ill;
  } row_t;

  row_t rows[11];
  logic [5:0] rand_ops[11];

  initial begin
    int cyc, mw, dn, il, model_ret, guard, idx, st;
    logic [31:0] r0;
    logic [5:0] op;
    logic [20:0] e;
    bit mr;

    rows[0]  = '{6'h23, -1, 0, 5, 0, 1, 0};
    rows[1]  = '{6'h2B, -1, 0, 4, 1, 1, 0};
    rows[2]  = '{6'h00, -1, 0, 4, 0, 1, 0};
    rows[3]  = '{6'h08, -1, 0, 4, 0, 1, 0};
    rows[4]  = '{6'h04, -1, 0, 3, 0, 1, 0};
    rows[5]  = '{6'h05, -1, 0, 3, 0, 1, 0};
    rows[6]  = '{6'h02, -1, 0, 3, 0, 1, 0};
    rows[7]  = '{6'h3F, -1, 0, 2, 0, 0, 1};
    rows[8]  = '{6'h23,  3, 2, 7, 0, 1, 0};
    rows[9]  = '{6'h2B,  5, 3, 7, 4, 1, 0};
    rows[10] = '{6'h00,  0, 1, 5, 0, 1, 0};
    rand_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02,
                 6'h3F, 6'h01, 6'h10, 6'h2A};

    reset = 1'b1; opcode = 6'h00; mem_ready = 1'b0;
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    check("reset_strobes", 64'(dut_vec()), 64'd0);
    check("reset_state", 64'(state), 64'd0);
    check("reset_retired", 64'(retired), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Latency / stall table
    for (int r = 0; r < 11; r++) begin
      r0 = retired;
      run_instr(rows[r].op, rows[r].stall_st, rows[r].stall_n, cyc, mw, dn, il);
      check($sformatf("row%0d_cycles", r), 64'(cyc), 64'(rows[r].exp_cycles));
      check($sformatf("row%0d_memwrite", r), 64'(mw), 64'(rows[r].exp_mw));
      check($sformatf("row%0d_done", r), 64'(dn), 64'(rows[r].exp_done));
      check($sformatf("row%0d_illegal", r), 64'(il), 64'(rows[r].exp_ill));
      check($sformatf("row%0d_retired", r), 64'(retired - r0), 64'(rows[r].exp_done));
    end

    // Reset while stalled in MEMRD
    opcode = 6'h23;
    for (int k = 0; k < 10 && state != 4'd3; k++) begin
      mem_ready = 1'b1;
      @(posedge clock); #1;
    end
    mem_ready = 1'b0;
    @(negedge clock);
    check("memrd_stall_state", 64'(state), 64'd3);
    check("memrd_stall_strobes", 64'(dut_vec()), 64'(exp_out(3, 1'b0, 6'h23)));
    reset = 1'b1;
    @(negedge clock);
    check("rst_hold_strobes", 64'(dut_vec()), 64'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_edge_strobes", 64'(dut_vec()), 64'd0);
    check("rst_edge_state", 64'(state), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_state", 64'(state), 64'd0);
    check("post_rst_retired", 64'(retired), 64'd0);
    check("post_rst_strobes", 64'(dut_vec()), 64'(exp_out(0, 1'b0, 6'h23)));
    @(posedge clock); #1;

    // Counter wrap on the 2-bit instance
    for (int k = 0; k < 3; k++) run_instr(6'h02, -1, 0, cyc, mw, dn, il);
    check("small_retired_3", 64'(s_retired), 64'd3);
    run_instr(6'h02, -1, 0, cyc, mw, dn, il);
    check("small_retired_wrap", 64'(s_retired), 64'd0);
    check("big_retired_4", 64'(retired), 64'd4);

    // Random instruction stream against the path model
    model_ret = 4;
    for (int n = 0; n < 200; n++) begin
      op = rand_ops[$urandom_range(0, 10)];
      idx = 0;
      guard = 0;
      while (path_state(op, idx) >= 0) begin
        st = path_state(op, idx);
        mr = (guard > 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
        opcode = op;
        mem_ready = mr;
        @(negedge clock);
        e = exp_out(st, mr, op);
        check($sformatf("rnd%0d_op%0h_state", n, op), 64'(state), 64'(st));
        check($sformatf("rnd%0d_op%0h_st%0d_strobes", n, op, st), 64'(dut_vec()), 64'(e));
        check($sformatf("rnd%0d_retired", n), 64'(retired), 64'(32'(model_ret)));
        check($sformatf("rnd%0d_small_retired", n), 64'(s_retired), 64'(model_ret % 4));
        if (e[1]) model_ret++;
        @(posedge clock); #1;
        guard++;
        if (!((st == 0 || st == 3 || st == 5) && !mr)) idx++;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
